// File: rtl/qerv_dbus_ram.sv
// Wishbone-classic data-bus responder backed by a word-addressed RAM, with WAIT programmable wait states.
// Optional QERV_DBUS_ERR_EN: out-of-range addresses get o_wb_err instead of wrapping.
module qerv_dbus_ram #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 0,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_TURN = 2'd3;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:2]   adr_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          oob;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    assign idx = adr_q[AW+1:2];

`ifdef QERV_DBUS_ERR_EN
    logic err_q;
    assign oob      = |adr_q[31:AW+2];
    assign o_wb_err = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= (state == S_RESP) && oob;
    end

    logic unused_lo;
    assign unused_lo = ^i_wb_adr[1:0];
`else
    // Upper address bits are simply dropped so the index wraps modulo DEPTH.
    assign oob      = 1'b0;
    assign o_wb_err = 1'b0;

    logic unused_hi;
    assign unused_hi = ^{adr_q[31:AW+2], i_wb_adr[1:0]};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= 1'b0;
            case (state)
                S_IDLE: if (i_wb_cyc) begin
                    if (WAIT == 0) begin
                        state <= S_RESP;
                    end else begin
                        cnt   <= 4'(WAIT - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP: begin
                    state <= S_TURN;
                    if (!oob) begin
                        o_wb_ack <= 1'b1;
                        if (!we_q) o_wb_rdt <= mem[idx];
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request fields are only captured in IDLE, so cyc glitches during WAIT are harmless.
    always_ff @(posedge i_clk) begin
        if (state == S_IDLE && i_wb_cyc) begin
            adr_q <= i_wb_adr[31:2];
            dat_q <= i_wb_dat;
            sel_q <= i_wb_sel;
            we_q  <= i_wb_we;
        end
    end

    // Reset in RESP must discard the pending write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state == S_RESP && we_q && !oob) begin
            for (int n = 0; n < 4; n++)
                if (sel_q[n]) mem[idx][8*n +: 8] <= dat_q[8*n +: 8];
        end
    end

endmodule

// File: tb/tb_qerv_dbus_ram.sv
// Bench for qerv_dbus_ram: two instances (WAIT=0 and WAIT=3) against an array-based memory model.
module tb_qerv_dbus_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, cyc0, cyc3;
    logic [31:0] rdt0, rdt3;
    logic        ack0, ack3, err0, err3;

    always #5 clk = ~clk;

    qerv_dbus_ram #(.DEPTH(256), .WAIT(0)) u_w0 (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc0), .o_wb_rdt(rdt0), .o_wb_ack(ack0), .o_wb_err(err0));

    qerv_dbus_ram #(.DEPTH(256), .WAIT(3)) u_w3 (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc3), .o_wb_rdt(rdt3), .o_wb_ack(ack3), .o_wb_err(err3));

`ifdef QERV_DBUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int nchk = 0;
    int nfail = 0;
    bit [31:0] m0 [256];
    bit [31:0] m3 [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete bus transaction on instance d (0 or 3); returns rdt seen with the response.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] dt,
                       input logic [3:0] s, output logic [31:0] got);
        int n;
        int idx;
        bit oob;
        logic [31:0] prev, word, mask;
        @(negedge clk);
        prev = (d == 0) ? rdt0 : rdt3;
        adr = a; dat = dt; sel = s; we = w;
        if (d == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!((d == 0) ? (ack0 | err0) : (ack3 | err3)) && n < 40);
        cyc0 = 1'b0; cyc3 = 1'b0;
        got = (d == 0) ? rdt0 : rdt3;
        chk("latency", 32'(n), (d == 0) ? 32'd2 : 32'd5);
        oob = ERR_EN && (a[31:10] != 22'd0);
        chk("ack", 32'((d == 0) ? ack0 : ack3), 32'(!oob));
        chk("err", 32'((d == 0) ? err0 : err3), 32'(oob));
        idx  = int'(a[9:2]);
        word = (d == 0) ? m0[idx] : m3[idx];
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (oob) begin
            chk("rdt_hold", got, prev);
        end else if (w) begin
            word = (word & ~mask) | (dt & mask);
            if (d == 0) m0[idx] = word; else m3[idx] = word;
        end else begin
            chk("rdt", got, word);
        end
        @(posedge clk); #1;
        chk("ack_width", 32'((d == 0) ? ack0 : ack3), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        int n;
        bit seen;
        rst = 1'b1; cyc0 = 1'b0; cyc3 = 1'b0; we = 1'b0;
        adr = '0; dat = '0; sel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack0", 32'(ack0), 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_rdt0", rdt0, 32'd0);
        chk("rst_ack3", 32'(ack3), 32'd0);
        chk("rst_rdt3", rdt3, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Fill both RAMs so every later read has a known model value.
        for (int i = 0; i < 256; i++) begin
            txn(0, 1'b1, 32'(i * 4), $urandom, 4'hF, got);
            txn(3, 1'b1, 32'(i * 4), $urandom, 4'hF, got);
        end

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, got);
        chk("wr_rd_0x10", got, 32'hDEADBEEF);

        txn(0, 1'b1, 32'h20, 32'h0, 4'hF, got);
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, got);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, got);
        chk("bytesel", got, 32'h00220044);

        txn(0, 1'b1, 32'h24, 32'h55555555, 4'h0, got);
        txn(0, 1'b0, 32'h24, 32'h0, 4'hF, got);

        txn(0, 1'b1, 32'h10, 32'h0BADC0DE, 4'hF, got);
        txn(0, 1'b0, 32'h13, 32'h0, 4'h1, got);
        chk("unaligned", got, 32'h0BADC0DE);

        txn(0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF, got);
        txn(0, 1'b1, 32'h400, 32'h12345678, 4'hF, got);
        txn(0, 1'b0, 32'h0, 32'h0, 4'hF, got);
        chk("wrap", got, ERR_EN ? 32'h55AA55AA : 32'h12345678);

        // WAIT=3 with cyc held through ack: second ack one full period later.
        txn(3, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, got);
        @(negedge clk);
        adr = 32'h40; we = 1'b0; sel = 4'hF; cyc3 = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack3 && n < 40);
        chk("held_lat", 32'(n), 32'd5);
        chk("held_rdt", rdt3, 32'hCAFEF00D);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack3 && n < 40);
        chk("held_period", 32'(n), 32'd6);
        cyc3 = 1'b0;
        @(posedge clk); #1;
        chk("held_width", 32'(ack3), 32'd0);

        // Reset during the second WAIT cycle drops the write.
        txn(3, 1'b1, 32'h4, 32'h0, 4'hF, got);
        txn(3, 1'b0, 32'h40, 32'h0, 4'hF, got);
        @(negedge clk);
        adr = 32'h4; dat = 32'hA5A5A5A5; sel = 4'hF; we = 1'b1; cyc3 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; cyc3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack3 || err3) seen = 1'b1;
        end
        chk("rst_noack", 32'(seen), 32'd0);
        chk("rst_rdt", rdt3, 32'd0);
        txn(3, 1'b0, 32'h4, 32'h0, 4'hF, got);
        chk("rst_nowrite", got, 32'h0);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            txn(($urandom_range(0, 1) == 0) ? 0 : 3, 1'($urandom_range(0, 1)), a,
                $urandom, 4'($urandom_range(0, 15)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/qerv_dbus_ram.md
Name: qerv_dbus_ram

Overview:
- Wishbone-classic data-bus responder: the target end of the qerv data bus.
- Accepts word-aligned addresses with byte selects from the core's dbus master and returns read data or write acknowledge after a programmable number of wait states.
- Backs a local word-addressed RAM; used as on-chip data memory in qerv SoC builds and in core testbenches.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 2.
- WAIT, 0, extra wait-state cycles between request capture and ack; 0..15.
- AW, $clog2(DEPTH), word-index width, derived; do not override.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active high.
- i_wb_adr  input  32  byte address; bits [1:0] ignored, word index = adr[AW+1:2].
- i_wb_dat  input  32  write data.
- i_wb_sel  input  4  byte enables; sel[n] enables dat[8n+7:8n].
- i_wb_we  input  1  1 = write, 0 = read.
- i_wb_cyc  input  1  request valid; held by master until ack.
- o_wb_rdt  output  32  read data; valid in the ack cycle, held until the next read ack.
- o_wb_ack  output  1  single-cycle acknowledge.
- o_wb_err  output  1  single-cycle error response; constant 0 unless QERV_DBUS_ERR_EN.

Behaviour:
- Reset values: o_wb_ack = 0, o_wb_err = 0, o_wb_rdt = 0, state = IDLE, wait counter = 0. RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP, TURN.
- IDLE:
  - i_wb_cyc = 1 captures adr, we, sel and dat into registers.
  - WAIT = 0: go to RESP.
  - Otherwise: load counter with WAIT-1 and go to WAIT.
- WAIT: decrement the counter; at 0, go to RESP. Inputs are not resampled.
- RESP: perform the access using the captured fields; o_wb_ack = 1 registered, visible in the cycle after RESP; go to TURN.
  - Write: for each n with sel[n] = 1, mem[idx] byte n <= dat byte n. sel = 0000 writes nothing but still acks.
  - Read: o_wb_rdt <= mem[idx], all 4 bytes regardless of sel.
- TURN: o_wb_ack high for exactly this cycle; i_wb_cyc ignored; return to IDLE.
  - A master that keeps cyc high after ack is seen as a new request in IDLE.
- Latency from cyc rising (IDLE sample) to ack: WAIT+2 cycles. Minimum back-to-back period: WAIT+3 cycles.
- Write and read to the same word in consecutive transactions: the read returns the new data; no bypass needed, because the write completes in RESP before the next capture.
- Address above DEPTH words: index wraps modulo DEPTH (upper bits ignored), unless QERV_DBUS_ERR_EN.
- i_wb_cyc dropped during WAIT: the transaction still completes and acks (protocol violation by the master; behaviour defined for robustness).
- i_rst asserted in any state: return to IDLE next cycle. No ack. A pending write is discarded and does not modify RAM. o_wb_rdt is cleared.
- o_wb_ack and o_wb_err are never high together.

Optional Feature:
- Macro QERV_DBUS_ERR_EN.
- Defined: in RESP, a captured address with any of bits [31:AW+2] set suppresses the access (no RAM write, o_wb_rdt unchanged). o_wb_err pulses in place of o_wb_ack, with the same timing.
- Undefined: o_wb_err tied 0; out-of-range addresses wrap as above.

Test Plan:
- WAIT=0. Write adr 0x10, dat 0xDEADBEEF, sel 1111, then read adr 0x10 -> ack 2 cycles after each cyc; rdt = 0xDEADBEEF.
- Byte select. Preload 0x00000000 at adr 0x20, write 0x11223344 with sel 0101 -> read returns 0x00220044.
- WAIT=3. Read of a preloaded word 0xCAFEF00D -> ack exactly 5 cycles after cyc sample; ack width 1; cyc held high through ack produces the next ack 6 cycles later.
- Reset mid-op. WAIT=3, write 0xA5A5A5A5 to adr 0x4 (word previously 0x0), assert i_rst in the second WAIT cycle -> no ack, o_wb_rdt = 0; later read of 0x4 returns 0x00000000.
- Wrap. DEPTH=256, write 0x12345678 to adr 0x400, read adr 0x0 -> 0x12345678; with QERV_DBUS_ERR_EN the write gives err=1, ack=0, and the read of 0x0 returns the old value.
- Unaligned address. Read adr 0x13 with word 0x10 = 0x0BADC0DE -> rdt 0x0BADC0DE; low 2 address bits ignored.
